// File: rtl/frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_pkg
// Description : Shared types and constants for the frame_tx_1001 serial
//               transmitter: FSM state encoding, sync word, parameter limits
//               and a small constant helper.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  localparam logic [3:0] SYNC_WORD = 4'b1001;
  localparam int         SYNC_W    = 4;

  localparam int PAYLOAD_W_MIN = 1;
  localparam int PAYLOAD_W_MAX = 32;
  localparam int GAP_LEN_MIN   = 0;
  localparam int GAP_LEN_MAX   = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tx_shreg.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_shreg
// Description : Parallel-load, MSB-out shift register. Load has priority over
//               shift; a shift moves the word one place toward the MSB and
//               fills the LSB with 0.
// Ports       : clk      - clock, rising edge
//               reset_n  - asynchronous active-low reset
//               i_load   - load i_data
//               i_shift  - shift left by one
//               i_data   - parallel load word
//               o_msb    - current MSB
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= r_data << 1;
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/frame_tx_1001.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_1001
// Description : Serial frame transmitter. A payload accepted over a
//               valid/ready handshake is sent as: sync word 1001, payload
//               MSB-first, optional even-parity bit, then GAP_LEN zero bits.
// Ports       : clk        - clock, rising edge
//               reset_n    - asynchronous active-low reset
//               tx_valid   - payload offered
//               tx_data    - payload word, sampled on acceptance only
//               tx_ready   - high only in IDLE
//               data_out   - registered serial line, 0 outside a frame
//               tx_busy    - high in any state other than IDLE
//               frame_done - pulse while the last frame bit is on data_out
// Config      : FRAME_TX_PARITY_EN - when defined, append one even-parity bit
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_1001
  import frame_tx_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int GAP_LEN   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 data_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  if (PAYLOAD_W < PAYLOAD_W_MIN || PAYLOAD_W > PAYLOAD_W_MAX) begin : g_bad_payload_w
    $error("frame_tx_1001: PAYLOAD_W out of range");
  end
  if (GAP_LEN < GAP_LEN_MIN || GAP_LEN > GAP_LEN_MAX) begin : g_bad_gap_len
    $error("frame_tx_1001: GAP_LEN out of range");
  end

  // The shared counter nominally needs $clog2(PAYLOAD_W+1) bits; it is widened
  // so that narrow payloads can still count the 4 sync bits and a long gap
  // without wrapping.
  localparam int CNT_W = max_int(max_int($clog2(PAYLOAD_W + 1), $clog2(SYNC_W)),
                                 $clog2(GAP_LEN + 1));

  localparam logic [CNT_W-1:0] c_SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] c_PAY_LAST  = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam state_t           c_AFTER_BODY = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_data_out;
  logic             r_frame_done;
  logic             w_dout_next;
  logic             w_done_next;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;
  logic [1:0]       w_sync_sel;

  frame_tx_shreg #(
    .WIDTH (PAYLOAD_W)
  ) u_shreg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (tx_data),
    .o_msb   (w_msb)
  );

`ifdef FRAME_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^tx_data;
    end
  end
`endif

  // data_out is registered, so every branch computes the bit that will be on
  // the line in the *next* cycle. The shift register is advanced in the same
  // edge that its MSB is copied into data_out.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_dout_next  = 1'b0;
    w_sync_sel   = 2'd2 - r_cnt[1:0];

    case (r_state)
      ST_IDLE: begin
        if (tx_valid) begin
          w_next_state = ST_SYNC;
          w_cnt_next   = '0;
          w_load       = 1'b1;
          w_dout_next  = SYNC_WORD[SYNC_W-1];
        end
      end

      ST_SYNC: begin
        if (r_cnt == c_SYNC_LAST) begin
          w_next_state = ST_PAYLOAD;
          w_cnt_next   = '0;
          w_shift      = 1'b1;
          w_dout_next  = w_msb;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
          w_dout_next  = SYNC_WORD[w_sync_sel];
        end
      end

      ST_PAYLOAD: begin
        if (r_cnt == c_PAY_LAST) begin
`ifdef FRAME_TX_PARITY_EN
          w_next_state = ST_PARITY;
          w_dout_next  = r_parity;
`else
          w_next_state = c_AFTER_BODY;
`endif
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
          w_shift      = 1'b1;
          w_dout_next  = w_msb;
        end
      end

`ifdef FRAME_TX_PARITY_EN
      ST_PARITY: begin
        w_next_state = c_AFTER_BODY;
        w_cnt_next   = '0;
      end
`endif

      ST_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_next_state = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_next_state = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Pulse is registered alongside the bit it marks as last.
`ifdef FRAME_TX_PARITY_EN
    w_done_next = (w_next_state == ST_PARITY);
`else
    w_done_next = (w_next_state == ST_PAYLOAD) && (w_cnt_next == c_PAY_LAST);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_data_out   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_cnt_next;
      r_data_out   <= w_dout_next;
      r_frame_done <= w_done_next;
    end
  end

  assign tx_ready   = (r_state == ST_IDLE);
  assign tx_busy    = (r_state != ST_IDLE);
  assign data_out   = r_data_out;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
